// File: rtl/apb_regfile_slave_if.sv
// APB bus bundle between a master and the register-file slave.
interface apb_regfile_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                      PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [ADDR_WIDTH-1:0]     PADDR;
  logic [DATA_WIDTH-1:0]     PWDATA;
  logic [DATA_WIDTH/8-1:0]   PSTRB;
  logic                      PREADY;
  logic [DATA_WIDTH-1:0]     PRDATA;
  logic                      PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_regfile_slave.sv
// APB slave bridging to an external register bank, with programmable wait
// states, address/read-only error decode and abort handling.
module apb_regfile_slave #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = '0
) (
  input  logic                        CLK,
  input  logic                        nRST,
  apb_regfile_slave_if.slave          apb,
  input  logic [DATA_WIDTH-1:0]       read_data,
  output logic [DATA_WIDTH-1:0]       write_data,
  output logic [DATA_WIDTH/8-1:0]     write_strobe,
  output logic                        write_enable,
  output logic [$clog2(NUM_REGS)-1:0] register_select
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW  = $clog2(NUM_REGS);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state, state_nx;
  logic [2:0]            cnt, cnt_nx;
  logic                  load, ready;
  logic                  wr_q, err_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         strb_q;
  logic [IW-1:0]         idx_q;

  // Address decode; subtraction wraps so addresses below BASE_ADDR land out of range.
  logic [ADDR_WIDTH-1:0] offset, index;
  logic [NUM_REGS-1:0]   ro_sh;
  logic                  dec_err;

  assign offset  = apb.PADDR - BASE_ADDR;
  assign index   = offset >> LSB;
  assign ro_sh   = RO_MASK >> index[IW-1:0];
  assign dec_err = (|(offset & ADDR_WIDTH'(NB-1)))
                || (index >= ADDR_WIDTH'(NUM_REGS))
                || (apb.PWRITE && ro_sh[0] && (|apb.PSTRB));

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    load     = 1'b0;
    ready    = 1'b0;
    case (state)
      IDLE: begin
        if (apb.PSEL && !apb.PENABLE) begin
          load     = 1'b1;
          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        if (!apb.PSEL) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (!apb.PENABLE) begin
          load = 1'b1;
        end else if (cnt != '0) begin
          cnt_nx = cnt - 3'd1;
        end else begin
          ready    = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (load) cnt_nx = 3'(WAIT_STATES);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      idx_q   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (load) begin
        wr_q    <= apb.PWRITE;
        err_q   <= dec_err;
        wdata_q <= apb.PWDATA;
        strb_q  <= apb.PSTRB;
        idx_q   <= index[IW-1:0];
      end
    end
  end

  // All outputs derive from state, so an asserted reset zeroes them at once.
  assign register_select = (state == ACCESS && !err_q) ? idx_q : '0;
  assign apb.PREADY      = ready;
  assign apb.PSLVERR     = ready && err_q;
  assign write_enable    = ready && wr_q && !err_q && (|strb_q);
  assign write_data      = write_enable ? wdata_q : '0;
  assign write_strobe    = write_enable ? strb_q : '0;
  assign apb.PRDATA      = (ready && !wr_q && !err_q) ? read_data : '0;
endmodule

// File: tb/tb_apb_regfile_slave.sv
// Randomized + directed bench for apb_regfile_slave against a transaction-level model.
module tb_apb_regfile_slave;
  localparam int          DW   = 32;
  localparam int          AW   = 32;
  localparam int          NR   = 16;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int          WS   = 3;
  localparam logic [15:0] RO   = 16'h0009;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] read_data, write_data;
  logic [3:0]  write_strobe, register_select;
  logic        write_enable;

  apb_regfile_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  apb_regfile_slave #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR),
    .BASE_ADDR(BASE), .WAIT_STATES(WS), .RO_MASK(RO)
  ) dut (
    .CLK(CLK), .nRST(nRST), .apb(bus.slave),
    .read_data(read_data), .write_data(write_data), .write_strobe(write_strobe),
    .write_enable(write_enable), .register_select(register_select)
  );

  always #5 CLK = ~CLK;

  // Register bank attached to the slave; loads its initial image until bank_init.
  logic [31:0] bank [NR];
  logic [31:0] mdl  [NR];
  logic        bank_init = 1'b0;

  function automatic logic [31:0] init_val(input int i);
    return (i == 3) ? 32'h0000_1234 : 32'h0101_0101 * i;
  endfunction

  always @(posedge CLK) begin
    if (!bank_init) begin
      for (int i = 0; i < NR; i++) bank[i] <= init_val(i);
    end else if (write_enable) begin
      for (int b = 0; b < 4; b++)
        if (write_strobe[b]) bank[register_select][8*b +: 8] <= write_data[8*b +: 8];
    end
  end
  assign read_data = bank[register_select];

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rdy"},  32'(bus.PREADY), 0);
    chk({tag, "_we"},   32'(write_enable), 0);
    chk({tag, "_err"},  32'(bus.PSLVERR), 0);
    chk({tag, "_rd"},   bus.PRDATA, 0);
    chk({tag, "_wd"},   write_data, 0);
  endtask

  task automatic drive_setup(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] strb);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
    bus.PADDR = addr; bus.PWDATA = wd; bus.PSTRB = strb;
  endtask

  // One complete transfer; sync=0 drives the setup immediately (caller is mid-cycle).
  task automatic xfer(input bit sync, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] strb);
    logic [31:0] off, idx, exp_rd;
    logic [15:0] ro_v;
    bit          err, exp_we, last;
    ro_v   = RO;
    off    = addr - BASE;
    idx    = off / 4;
    err    = (off % 4 != 0) || (idx >= NR) || (wr && ro_v[idx[3:0]] && strb != 0);
    exp_we = wr && !err && strb != 0;
    exp_rd = (!wr && !err) ? mdl[idx[3:0]] : 32'h0;
    if (sync) begin @(posedge CLK); #1; end
    drive_setup(wr, addr, wd, strb);
    @(negedge CLK);
    chk("setup_rdy", 32'(bus.PREADY), 0);
    for (int c = 1; c <= WS + 1; c++) begin
      @(posedge CLK); #1;
      bus.PENABLE = 1'b1;
      @(negedge CLK);
      last = (c == WS + 1);
      chk("pready",  32'(bus.PREADY), 32'(last));
      chk("rsel",    32'(register_select), err ? 0 : idx);
      chk("we",      32'(write_enable), 32'(last && exp_we));
      chk("pslverr", 32'(bus.PSLVERR), 32'(last && err));
      chk("prdata",  bus.PRDATA, last ? exp_rd : 32'h0);
      if (last) begin
        chk("wdata", write_data, exp_we ? wd : 32'h0);
        chk("wstrb", 32'(write_strobe), exp_we ? 32'(strb) : 0);
      end
    end
    if (exp_we)
      for (int b = 0; b < 4; b++)
        if (strb[b]) mdl[idx[3:0]][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] addr, wd;
    logic [3:0]  strb;
    bit          wr;
    int          r;
    for (int i = 0; i < NR; i++) mdl[i] = init_val(i);
    drive_setup(1'b0, 32'h0, 32'h0, 4'h0);
    bus.PSEL = 1'b0;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    bank_init = 1'b1;
    chk_quiet("rst");
    chk("rst_rsel", 32'(register_select), 0);
    @(negedge CLK);
    nRST = 1'b1;

    // Directed: first setup on first edge after release, then back-to-back
    xfer(0, 1'b1, BASE + 32'h8,  32'hDEAD_BEEF, 4'hF);
    xfer(1, 1'b0, BASE + 32'hC,  32'h0, 4'h0);
    xfer(1, 1'b0, BASE + 32'h40, 32'h0, 4'h0);
    xfer(1, 1'b1, BASE + 32'h6,  32'h5555_5555, 4'hF);
    xfer(1, 1'b1, BASE + 32'h0,  32'hAAAA_AAAA, 4'h3);
    xfer(1, 1'b1, BASE + 32'h0,  32'hAAAA_AAAA, 4'h0);
    xfer(1, 1'b0, BASE - 32'h4,  32'h0, 4'h0);
    xfer(1, 1'b0, BASE + 32'h8,  32'h0, 4'h0);
    idle(2);

    // PENABLE without setup is ignored
    @(posedge CLK); #1;
    drive_setup(1'b0, BASE + 32'h8, 32'h0, 4'h0);
    bus.PENABLE = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("noset_rdy", 32'(bus.PREADY), 0);
      chk("noset_rsel", 32'(register_select), 0);
    end
    idle(1);

    // Abort by PSEL drop after one access cycle
    @(posedge CLK); #1;
    drive_setup(1'b1, BASE + 32'h18, 32'h1111_2222, 4'hF);
    @(posedge CLK); #1;
    bus.PENABLE = 1'b1;
    @(posedge CLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      chk_quiet("abort");
      @(posedge CLK); #1;
    end
    xfer(1, 1'b0, BASE + 32'h18, 32'h0, 4'h0);
    idle(1);

    // Fresh setup mid-access restarts the transfer
    @(posedge CLK); #1;
    drive_setup(1'b1, BASE + 32'h14, 32'h7777_7777, 4'hF);
    @(posedge CLK); #1;
    bus.PENABLE = 1'b1;
    @(negedge CLK);
    chk("relatch_rdy", 32'(bus.PREADY), 0);
    xfer(1, 1'b0, BASE + 32'h14, 32'h0, 4'h0);
    idle(1);

    // Asynchronous reset during the wait phase
    @(posedge CLK); #1;
    drive_setup(1'b1, BASE + 32'h18, 32'h3333_4444, 4'hF);
    @(posedge CLK); #1;
    bus.PENABLE = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("pre_rst_rsel", 32'(register_select), 6);
    #1 nRST = 1'b0;
    #1;
    chk_quiet("arst");
    chk("arst_rsel", 32'(register_select), 0);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk_quiet("arst_hold");
    nRST = 1'b1;
    xfer(0, 1'b0, BASE + 32'h4, 32'h0, 4'h0);
    xfer(1, 1'b0, BASE + 32'h18, 32'h0, 4'h0);

    // Randomized traffic
    for (int t = 0; t < 80; t++) begin
      wr = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      if (r < 6)       addr = BASE + 32'(4 * $urandom_range(0, NR - 1));
      else if (r == 6) addr = BASE + 32'($urandom_range(0, 63));
      else if (r == 7) addr = BASE + 32'h40 + 32'(4 * $urandom_range(0, 20));
      else if (r == 8) addr = BASE - 32'(4 * $urandom_range(1, 8));
      else             addr = $urandom;
      wd   = $urandom;
      strb = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      xfer(1, wr, addr, wd, strb);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(2);

    for (int i = 0; i < NR; i++) chk("bank", bank[i], mdl[i]);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/apb_regfile_slave.md
APB_REGFILE_SLAVE -- requirements
Module: apb_regfile_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: APB data width; a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: PADDR width.
REQ-003 SHALL have parameter NUM_REGS, default 16: number of control registers addressed; range 2..256.
REQ-004 SHALL have parameter BASE_ADDR, default 0: byte address of register 0.
REQ-005 SHALL have parameter WAIT_STATES, default 0: extra access-phase cycles before PREADY; range 0..7.
REQ-006 SHALL have parameter RO_MASK, NUM_REGS bits, default 0: bit i=1 marks register i read-only.
REQ-007 SHALL have the following ports. One clock; reset is asynchronous and active-low.
- CLK  in  1  clock; all state on rising edge
- nRST  in  1  asynchronous active-low reset
- PSEL  in  1  slave selected
- PENABLE  in  1  access phase
- PWRITE  in  1  1=write, 0=read
- PADDR  in  ADDR_WIDTH  byte address
- PWDATA  in  DATA_WIDTH  write data
- PSTRB  in  DATA_WIDTH/8  byte-lane write strobes
- PREADY  out  1  transfer completes this cycle
- PRDATA  out  DATA_WIDTH  read data
- PSLVERR  out  1  transfer error; valid only with PREADY
- read_data  in  DATA_WIDTH  contents of selected register
- write_data  out  DATA_WIDTH  data to register bank
- write_strobe  out  DATA_WIDTH/8  byte lanes to update
- write_enable  out  1  one-cycle register write pulse
- register_select  out  max(1,clog2(NUM_REGS))  register index

Function
REQ-008 SHALL implement FSM IDLE -> ACCESS -> IDLE; ACCESS holds a 3-bit wait counter.
REQ-009 IDLE: PSEL=1 and PENABLE=0 (setup) SHALL latch PWRITE, PWDATA, PSTRB, decoded index and error flag, load counter=WAIT_STATES, go to ACCESS.
REQ-010 Decode: offset=PADDR-BASE_ADDR (ADDR_WIDTH wrap-around arithmetic); index=offset/(DATA_WIDTH/8).
REQ-011 Error flag SHALL be set if offset low log2(DATA_WIDTH/8) bits nonzero, index>=NUM_REGS (incl. PADDR<BASE_ADDR via wrap), or write to a register with RO_MASK bit set and PSTRB nonzero.
REQ-012 ACCESS with PSEL=1, PENABLE=1, counter>0: decrement counter; PREADY=0.
REQ-013 ACCESS with PSEL=1, PENABLE=1, counter=0: PREADY=1 combinationally this cycle; next state IDLE.
REQ-014 Latency: PREADY SHALL assert exactly WAIT_STATES+1 cycles after the setup cycle.
REQ-015 register_select SHALL equal latched index throughout ACCESS; 0 in IDLE and on error.
REQ-016 Write, PREADY cycle, no error, PSTRB nonzero: write_enable=1 for that one cycle with write_data=latched PWDATA, write_strobe=latched PSTRB.
REQ-017 Write with PSTRB=0: completes with PSLVERR=0 and write_enable=0.
REQ-018 Read, PREADY cycle, no error: PRDATA=read_data; PRDATA=0 in all other cycles.
REQ-019 Error transfer: PSLVERR=1 with PREADY, PRDATA=0, write_enable=0; no register modified.
REQ-020 PSLVERR, write_enable SHALL be 0 whenever PREADY=0; write_data, write_strobe 0 when write_enable=0.
REQ-021 PSEL dropping to 0 in ACCESS SHALL abort: next state IDLE, no PREADY, no write_enable.
REQ-022 PENABLE=0 with PSEL=1 in ACCESS (new setup) SHALL be treated as abort plus fresh setup: relatch and reload counter.
REQ-023 PENABLE=1 in IDLE (no preceding setup) SHALL be ignored; PREADY stays 0.
REQ-024 Back-to-back: setup in the cycle after PREADY SHALL be accepted without idle gap.

Reset
REQ-025 nRST=0 SHALL asynchronously force state IDLE, counter 0, all latched fields 0, and all outputs 0.
REQ-026 Reset mid-ACCESS SHALL drop the transfer; no write_enable in or after the reset cycle.
REQ-027 First setup SHALL be accepted on the first rising edge with nRST=1.

Verification
REQ-028 Defaults, write PADDR=0x8, PWDATA=0xDEADBEEF, PSTRB=0xF -> PREADY 1 cycle after setup, write_enable=1, register_select=2, write_data=0xDEADBEEF, PSLVERR=0.
REQ-029 WAIT_STATES=3, read PADDR=0xC, read_data=0x1234 -> PREADY 4 cycles after setup, PRDATA=0x1234, register_select=3 for all 4 cycles.
REQ-030 Defaults, read PADDR=0x40 and write PADDR=0x6 -> each PSLVERR=1 with PREADY, PRDATA=0, write_enable never 1.
REQ-031 RO_MASK=0x0001, write PADDR=0x0, PSTRB=0x3 -> PSLVERR=1, write_enable=0; same with PSTRB=0 -> PSLVERR=0, write_enable=0.
REQ-032 WAIT_STATES=2, write setup then PSEL=0 after 1 access cycle -> no PREADY, no write_enable; next setup completes normally.
REQ-033 WAIT_STATES=5, nRST=0 asynchronously during access wait 2 -> all outputs 0 immediately; after release, read PADDR=0x4 completes in 6 cycles.
